// File: rtl/edge_filter_core_if.sv
// Pixel-stream interface for edge_filter_core.
// The master drives the frame/pixel inputs; the slave is the filter core.
interface edge_filter_core_if #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 8
);
  logic              iStart;
  logic              iMode;
  logic [DATA_W-1:0] iData;
  logic              iValid;
  logic [OUT_W-1:0]  oData;
  logic              oValid;
  logic              oEof;
  logic              oBusy;

  modport master (
    output iStart, iMode, iData, iValid,
    input  oData, oValid, oEof, oBusy
  );

  modport slave (
    input  iStart, iMode, iData, iValid,
    output oData, oValid, oEof, oBusy
  );
endinterface

// File: rtl/edge_filter_core.sv
// 3x3 Scharr/Sobel gradient-magnitude filter over a raster frame.
// Two line buffers, a 2-column window history and a 2-stage pipeline.
module edge_filter_core #(
  parameter int IMAGE_WIDTH  = 16,
  parameter int IMAGE_HEIGHT = 16,
  parameter int DATA_W       = 8,
  parameter int OUT_W        = 8
) (
  input logic               iClk,
  input logic               iRst,
  edge_filter_core_if.slave bus
);
  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam int RW = $clog2(IMAGE_HEIGHT);
  localparam int PW = $clog2(IMAGE_WIDTH + 2);
  localparam int GW = DATA_W + 6;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;
  typedef logic [DATA_W-1:0] pix_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  pcol_q, ccol_q;
  logic [RW-1:0]  prow_q, crow_q;
  logic [PW-1:0]  pre_q, fl_q;
  logic           drn_q, mode_q;
  logic           push, start, emit, last_in;
  pix_t           pix;

  pix_t lb1 [IMAGE_WIDTH];
  pix_t lb2 [IMAGE_WIDTH];
  pix_t at_q, am_q, ab_q, bt_q, bm_q, bb_q;
  pix_t nt, nm;

  logic signed [GW-1:0] gx, gy, gx1_q, gy1_q;
  logic        [GW-1:0] ax, ay, mag;
  logic                 v1_q, bd1_q, eof1_q, sat;
  logic                 border, last_c;
  logic [OUT_W-1:0]     odata_q;
  logic                 ovalid_q, oeof_q;

  assign last_in = prow_q == RW'(IMAGE_HEIGHT-1)
                && pcol_q == CW'(IMAGE_WIDTH-1);
  assign emit    = push && pre_q == PW'(IMAGE_WIDTH+1);

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    start   = 1'b0;
    pix     = '0;
    unique case (state_q)
      IDLE: if (bus.iStart) begin
        state_d = RUN;
        start   = 1'b1;
      end
      RUN: if (bus.iValid) begin
        push = 1'b1;
        pix  = bus.iData;
        if (last_in) state_d = FLUSH;
      end
      FLUSH: begin
        push = 1'b1;
        if (fl_q == PW'(IMAGE_WIDTH)) state_d = DRAIN;
      end
      DRAIN: if (drn_q) state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q <= IDLE;
      pcol_q  <= '0;
      prow_q  <= '0;
      ccol_q  <= '0;
      crow_q  <= '0;
      pre_q   <= '0;
      fl_q    <= '0;
      drn_q   <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drn_q   <= state_q == DRAIN && !drn_q;
      if (start) begin
        pcol_q <= '0;
        prow_q <= '0;
        ccol_q <= '0;
        crow_q <= '0;
        pre_q  <= '0;
        fl_q   <= '0;
        mode_q <= bus.iMode;
      end else if (push) begin
        if (pcol_q == CW'(IMAGE_WIDTH-1)) begin
          pcol_q <= '0;
          prow_q <= prow_q + 1'b1;
        end else begin
          pcol_q <= pcol_q + 1'b1;
        end
        if (!emit) pre_q <= pre_q + 1'b1;
        if (state_q == FLUSH) fl_q <= fl_q + 1'b1;
        if (emit) begin
          if (ccol_q == CW'(IMAGE_WIDTH-1)) begin
            ccol_q <= '0;
            crow_q <= crow_q + 1'b1;
          end else begin
            ccol_q <= ccol_q + 1'b1;
          end
        end
      end
    end
  end

  assign nt = lb2[pcol_q];
  assign nm = lb1[pcol_q];

  // Window keeps the two previous columns; the incoming column is the third.
  always_ff @(posedge iClk) begin
    if (push) begin
      lb2[pcol_q] <= nm;
      lb1[pcol_q] <= pix;
      at_q <= bt_q;
      am_q <= bm_q;
      ab_q <= bb_q;
      bt_q <= nt;
      bm_q <= nm;
      bb_q <= pix;
    end
  end

  function automatic logic [GW-1:0] wsum(
    input pix_t p0, input pix_t p1, input pix_t p2, input logic m
  );
    logic [GW-1:0] e, c;
    e = GW'(p0) + GW'(p2);
    c = GW'(p1);
    return m ? e + (c << 1)
             : (e << 1) + e + (c << 3) + (c << 1);
  endfunction

  // Gradients use the window as it will be after this push.
  always_comb begin
    gx = signed'(wsum(nt, nm, pix, mode_q))
       - signed'(wsum(at_q, am_q, ab_q, mode_q));
    gy = signed'(wsum(ab_q, bb_q, pix, mode_q))
       - signed'(wsum(at_q, bt_q, nt, mode_q));
  end

  assign border = crow_q == '0 || crow_q == RW'(IMAGE_HEIGHT-1)
               || ccol_q == '0 || ccol_q == CW'(IMAGE_WIDTH-1);
  assign last_c = crow_q == RW'(IMAGE_HEIGHT-1)
               && ccol_q == CW'(IMAGE_WIDTH-1);

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      v1_q   <= 1'b0;
      eof1_q <= 1'b0;
      bd1_q  <= 1'b0;
      gx1_q  <= '0;
      gy1_q  <= '0;
    end else begin
      v1_q   <= emit;
      eof1_q <= emit && last_c;
      bd1_q  <= border;
      gx1_q  <= gx;
      gy1_q  <= gy;
    end
  end

  assign ax  = gx1_q[GW-1] ? GW'(-gx1_q) : GW'(gx1_q);
  assign ay  = gy1_q[GW-1] ? GW'(-gy1_q) : GW'(gy1_q);
  assign mag = ax + ay;
  assign sat = |(mag >> OUT_W);

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      ovalid_q <= 1'b0;
      oeof_q   <= 1'b0;
      odata_q  <= '0;
    end else begin
      ovalid_q <= v1_q;
      oeof_q   <= eof1_q;
      odata_q  <= bd1_q ? '0 : (sat ? '1 : OUT_W'(mag));
    end
  end

  assign bus.oData  = odata_q;
  assign bus.oValid = ovalid_q;
  assign bus.oEof   = oeof_q;
  assign bus.oBusy  = state_q != IDLE;
endmodule

// File: tb/tb_edge_filter_core.sv
// Bench for edge_filter_core: directed and random frames
// checked against a direct 3x3 convolution reference.
module tb_edge_filter_core;
  localparam int W  = 16;
  localparam int H  = 16;
  localparam int N  = W * H;
  localparam int DW = 8;
  localparam int OW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  edge_filter_core_if #(.DATA_W(DW), .OUT_W(OW)) bus();

  edge_filter_core #(
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H),
    .DATA_W(DW), .OUT_W(OW)
  ) dut (
    .iClk(clk),
    .iRst(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int img [N];
  int acc [N];
  int q_d [$];
  int q_e [$];
  int q_c [$];
  int stray = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.oValid) begin
        q_d.push_back(int'(bus.oData));
        q_e.push_back(int'(bus.oEof));
        q_c.push_back(cyc);
      end else if (bus.oEof) begin
        stray++;
      end
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int px(int r, int c);
    return img[r*W + c];
  endfunction

  function automatic int model(int n, bit m);
    int r, c, gx, gy, mag;
    int k [3];
    r = n / W;
    c = n % W;
    if (r == 0 || r == H-1 || c == 0 || c == W-1) return 0;
    k[0] = m ? 1 : 3;
    k[1] = m ? 2 : 10;
    k[2] = k[0];
    gx = 0;
    gy = 0;
    for (int i = -1; i <= 1; i++) begin
      gx += k[i+1] * (px(r+i, c+1) - px(r+i, c-1));
      gy += k[i+1] * (px(r+1, c+i) - px(r-1, c+i));
    end
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return mag > 255 ? 255 : mag;
  endfunction

  task automatic clear_q();
    q_d.delete();
    q_e.delete();
    q_c.delete();
    stray = 0;
  endtask

  task automatic set_step(int lo, int hi);
    for (int i = 0; i < N; i++) img[i] = (i % W < 8) ? lo : hi;
  endtask

  task automatic feed(bit m, int duty, bit noise, int npix);
    int idx;
    bit v;
    @(negedge clk);
    bus.iStart = 1'b1;
    bus.iMode  = m;
    @(negedge clk);
    bus.iStart = 1'b0;
    bus.iMode  = 1'($urandom);
    chk("busy_after_start", bus.oBusy, 1);
    idx = 0;
    while (idx < npix) begin
      v = $urandom_range(99) < duty;
      bus.iValid = v;
      bus.iData  = v ? DW'(img[idx]) : DW'($urandom);
      if (v) begin
        acc[idx] = cyc;
        idx++;
      end
      bus.iStart = noise && ($urandom_range(7) == 0);
      @(negedge clk);
    end
    bus.iValid = 1'b0;
    bus.iStart = 1'b0;
  endtask

  task automatic run_frame(string tag, bit m, int duty, bit noise);
    int t;
    clear_q();
    if (noise) begin
      repeat (3) begin
        @(negedge clk);
        bus.iValid = 1'b1;
        bus.iData  = DW'($urandom);
      end
      @(negedge clk);
      bus.iValid = 1'b0;
    end
    feed(m, duty, noise, N);
    t = 0;
    while (bus.oBusy && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_busy_drop"}, t < 3000, 1);
    repeat (3) @(negedge clk);
    chk({tag, "_count"}, q_d.size(), N);
    chk({tag, "_stray_eof"}, stray, 0);
    chk({tag, "_busy_idle"}, bus.oBusy, 0);
    for (int n = 0; n < N && n < q_d.size(); n++) begin
      chk($sformatf("%s_data[%0d]", tag, n), q_d[n], model(n, m));
      chk($sformatf("%s_eof[%0d]", tag, n), q_e[n], n == N-1);
      if (n + W + 1 < N)
        chk($sformatf("%s_lat[%0d]", tag, n), q_c[n], acc[n+W+1] + 2);
    end
  endtask

  initial begin
    bus.iStart = 1'b0;
    bus.iMode  = 1'b0;
    bus.iValid = 1'b0;
    bus.iData  = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", bus.oValid, 0);
    chk("rst_eof", bus.oEof, 0);
    chk("rst_busy", bus.oBusy, 0);
    chk("rst_data", bus.oData, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < N; i++) img[i] = 100;
    run_frame("flat", 1'b0, 100, 1'b0);

    set_step(0, 10);
    run_frame("step_scharr", 1'b0, 100, 1'b0);
    if (q_d.size() > 24) begin
      chk("step_scharr_c7", q_d[W+7], 160);
      chk("step_scharr_c8", q_d[W+8], 160);
    end
    run_frame("step_sobel", 1'b1, 100, 1'b0);
    if (q_d.size() > 24) chk("step_sobel_c7", q_d[W+7], 40);

    set_step(0, 255);
    run_frame("step_sat", 1'b0, 100, 1'b0);
    if (q_d.size() > 24) chk("step_sat_c8", q_d[W+8], 255);

    set_step(0, 10);
    run_frame("step_gaps", 1'b0, 50, 1'b0);
    if (q_c.size() > 17) chk("lat_c17", q_c[17], acc[34] + 2);

    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < N; i++) img[i] = $urandom_range(255);
      run_frame($sformatf("rand%0d", f), 1'($urandom),
                $urandom_range(100, 30), 1'b1);
    end

    for (int i = 0; i < N; i++) img[i] = 100;
    clear_q();
    feed(1'b0, 100, 1'b0, 100);
    chk("pre_rst_valid", bus.oValid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.oValid, 0);
    chk("mid_rst_eof", bus.oEof, 0);
    chk("mid_rst_busy", bus.oBusy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame("after_rst", 1'b0, 100, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/edge_filter_core.md
Name: edge_filter_core

Overview:
- Parametrised 3x3 gradient-magnitude edge filter for the SNN front end.
- Accepts one raster-scanned frame of IMAGE_WIDTH x IMAGE_HEIGHT pixels per iStart. Emits exactly one result per pixel, in raster order, with border pixels forced to zero.
- Adds over the previous core: runtime Scharr/Sobel selection, a configurable frame height and pixel width, and an internal flush so the last rows are produced without extra input. It also exposes frame-level busy and end-of-frame status.

Parameters:
- IMAGE_WIDTH, 16, pixels per row; must be >= 3.
- IMAGE_HEIGHT, 16, rows per frame; must be >= 3.
- DATA_W, 8, input pixel width in bits.
- OUT_W, 8, output magnitude width in bits; saturation ceiling is 2^OUT_W-1.

Ports:
- iClk  in  1  clock.
- iRst  in  1  asynchronous active-low reset.
- iStart  in  1  single-cycle frame start; honoured only while oBusy=0.
- iMode  in  1  kernel select, sampled at accepted iStart: 0 = Scharr (3,10,3), 1 = Sobel (1,2,1).
- iData  in  DATA_W  pixel, unsigned.
- iValid  in  1  pixel qualifier; accepted only in RUN.
- oData  out  OUT_W  saturated |Gx|+|Gy|, or 0 at the border.
- oValid  out  1  oData qualifier.
- oEof  out  1  high together with the oValid of the frame's last result.
- oBusy  out  1  high from accepted iStart until the last result has been emitted.

Behaviour:
- Reset: iRst=0 asynchronously clears the FSM to IDLE, all counters, the pipeline valid bits, oValid, oEof, oBusy and oData (to 0). Line-buffer and window contents are not reset.
- FSM states: IDLE, RUN, FLUSH, DRAIN.
  - IDLE: iValid is ignored.
  - IDLE -> RUN on iStart. Counters are cleared, iMode is latched, and oBusy=1 from the next cycle.
  - RUN: each iValid=1 cycle accepts one pixel, writes the line buffers, shifts the window and advances the column/row counters. Column wraps at IMAGE_WIDTH-1; row increments on wrap.
  - RUN -> FLUSH on acceptance of pixel (IMAGE_HEIGHT-1, IMAGE_WIDTH-1).
  - FLUSH: injects IMAGE_WIDTH+1 zero pixels, one per cycle, unconditionally. iValid is ignored.
  - FLUSH -> DRAIN for 2 cycles, then DRAIN -> IDLE. oBusy falls on the IDLE entry edge.
- iStart while oBusy=1 is ignored, with no effect on the current frame.
- Indexing:
  - Center pixel n = r*IMAGE_WIDTH + c.
  - The result for n is computed when input index n+IMAGE_WIDTH+1 (real or flush) enters the window.
  - Results appear in strictly increasing n, exactly IMAGE_WIDTH*IMAGE_HEIGHT per frame.
- Latency: oValid for center n is asserted exactly 2 cycles after the cycle that accepted or injected index n+IMAGE_WIDTH+1.
  - Stage 1 registers Gx and Gy.
  - Stage 2 registers the magnitude and the saturated oData.
  - Gaps in iValid stall the pipeline front only; results already in flight still emerge on schedule.
- Kernel:
  - Weights (a,b,a) = (3,10,3) for Scharr, (1,2,1) for Sobel.
  - Gx = a*(R0+R2) + b*R1 - a*(L0+L2) - b*L1, where L and R are the left and right window columns.
  - Gy = a*(B0+B2) + b*B1 - a*(T0+T2) - b*T1, where T and B are the top and bottom window rows.
  - Multiplies are implemented as shift-add only.
  - Internal signed width is DATA_W+6; maximum |G| = 16*(2^DATA_W-1).
- Magnitude: |Gx|+|Gy|, unsigned DATA_W+6 bits, clamped to 2^OUT_W-1 when it exceeds the ceiling.
- Border: centers with r=0, r=IMAGE_HEIGHT-1, c=0 or c=IMAGE_WIDTH-1 output 0 with oValid=1. This masking covers windows that span row wrap and flush data.
- oEof: asserted only with the result for n = IMAGE_WIDTH*IMAGE_HEIGHT-1, which lands 2 cycles after the last flush injection. oEof=0 at all other times.
- Back-to-back frames: iStart is accepted in the first cycle with oBusy=0. The line buffers are fully rewritten before any interior result depends on them, so no clear is needed.
- Reset mid-frame: outputs drop asynchronously, no oEof is produced for the aborted frame, and the next iStart begins a clean frame.

Test Plan:
- Flat frame, 16x16, all pixels 100, Scharr -> 256 oValid pulses, every oData=0, oEof only on the 256th, oBusy low thereafter.
- Vertical step (cols 0-7=0, cols 8-15=10), Scharr -> interior centers at cols 7 and 8 give 160, all other results 0. Same frame with iMode=1 -> 40.
- Step 0/255, Scharr -> interior edge results 255, saturated from 4080. OUT_W=12 build -> 4080.
- Step frame with random 50% iValid duty -> result sequence identical to the gap-free run. Center 17's oValid occurs exactly 2 cycles after pixel 34 is accepted.
- iRst pulsed low after 100 accepted pixels -> oValid, oEof and oBusy are 0 within the same cycle. A following iStart plus a full flat frame yields 256 zeros and one oEof.
- iValid pulses in IDLE, and iStart during RUN -> no extra pixels accepted, no restart, counts unchanged (exactly 256 results).
